// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder for the multi-cycle datapath.
// Owns the mult/div busy FSM and back-pressures issue while the iterative unit runs.
module alu_ctrl_seq #(
  parameter int OPER_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_op,
  input  logic [5:0]        func,
  output logic              out_valid,
  output logic [OPER_W-1:0] alu_oper,
  output logic              jr,
  output logic              link,
  output logic              shamt_sel,
  output logic [1:0]        hilo_rd,
  output logic              illegal,
  output logic              md_start,
  output logic [1:0]        md_op,
  output logic              md_busy,
  output logic              md_done
);

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_NOR  = 4'h4;
  localparam logic [3:0] OP_SRL  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRA  = 4'h9;
  localparam logic [3:0] OP_SLTU = 4'hA;
  localparam logic [3:0] OP_LUI  = 4'hB;

  // The counter holds LAT-1 so that md_done lands exactly LAT cycles after md_start.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;

  logic [3:0]        dec_oper;
  logic              dec_jr, dec_link, dec_shamt, dec_illegal, dec_md;
  logic [1:0]        dec_hilo;

  logic              out_valid_q, out_valid_d;
  logic [OPER_W-1:0] alu_oper_q, alu_oper_d;
  logic              jr_q, jr_d, link_q, link_d, shamt_sel_q, shamt_sel_d;
  logic [1:0]        hilo_rd_q, hilo_rd_d;
  logic              illegal_q, illegal_d, md_start_q, md_start_d, md_done_q, md_done_d;
  logic [1:0]        md_op_q, md_op_d;

  assign accept = in_valid && (state_q == IDLE);

  always_comb begin
    dec_oper    = OP_ADD;
    dec_jr      = 1'b0;
    dec_link    = 1'b0;
    dec_shamt   = 1'b0;
    dec_hilo    = 2'b00;
    dec_illegal = 1'b0;
    dec_md      = 1'b0;
    case (alu_op)
      3'b001: dec_oper = OP_SUB;
      3'b011: dec_oper = OP_SLT;
      3'b100: dec_oper = OP_AND;
      3'b101: dec_oper = OP_OR;
      3'b110: dec_oper = OP_LUI;
      3'b111: dec_oper = OP_XOR;
      3'b010: begin
        case (func)
          6'h20, 6'h21: dec_oper = OP_ADD;
          6'h22, 6'h23: dec_oper = OP_SUB;
          6'h24:        dec_oper = OP_AND;
          6'h25:        dec_oper = OP_OR;
          6'h26:        dec_oper = OP_XOR;
          6'h27:        dec_oper = OP_NOR;
          6'h2A:        dec_oper = OP_SLT;
          6'h2B:        dec_oper = OP_SLTU;
          6'h00:        begin dec_oper = OP_SLL; dec_shamt = 1'b1; end
          6'h04:        dec_oper = OP_SLL;
          6'h02:        begin dec_oper = OP_SRL; dec_shamt = 1'b1; end
          6'h06:        dec_oper = OP_SRL;
          6'h03:        begin dec_oper = OP_SRA; dec_shamt = 1'b1; end
          6'h07:        dec_oper = OP_SRA;
          6'h08:        dec_jr = 1'b1;
          6'h09:        begin dec_jr = 1'b1; dec_link = 1'b1; end
          6'h10:        dec_hilo = 2'b10;
          6'h12:        dec_hilo = 2'b01;
          6'h18, 6'h19, 6'h1A, 6'h1B: dec_md = 1'b1;
          default:      dec_illegal = 1'b1;
        endcase
      end
      default: dec_oper = OP_ADD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The zero check happens before any decrement, so the counter never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && dec_md) begin
          state_d = BUSY;
          cnt_d   = func[1] ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = accept;
    alu_oper_d  = alu_oper_q;
    if (accept) begin
      alu_oper_d      = '0;
      alu_oper_d[3:0] = dec_oper;
    end
    jr_d        = accept && dec_jr;
    link_d      = accept && dec_link;
    shamt_sel_d = accept && dec_shamt;
    hilo_rd_d   = accept ? dec_hilo : 2'b00;
    illegal_d   = accept && dec_illegal;
    md_start_d  = accept && dec_md;
    md_op_d     = (accept && dec_md) ? func[1:0] : md_op_q;
    md_done_d   = (state_q == BUSY) && (cnt_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_oper_q  <= '0;
      jr_q        <= 1'b0;
      link_q      <= 1'b0;
      shamt_sel_q <= 1'b0;
      hilo_rd_q   <= 2'b00;
      illegal_q   <= 1'b0;
      md_start_q  <= 1'b0;
      md_op_q     <= 2'b00;
      md_done_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_oper_q  <= alu_oper_d;
      jr_q        <= jr_d;
      link_q      <= link_d;
      shamt_sel_q <= shamt_sel_d;
      hilo_rd_q   <= hilo_rd_d;
      illegal_q   <= illegal_d;
      md_start_q  <= md_start_d;
      md_op_q     <= md_op_d;
      md_done_q   <= md_done_d;
    end
  end

  // md_busy follows the state directly so that reset clears it without waiting for a clock.
  assign in_ready  = (state_q == IDLE);
  assign md_busy   = (state_q == BUSY);
  assign out_valid = out_valid_q;
  assign alu_oper  = alu_oper_q;
  assign jr        = jr_q;
  assign link      = link_q;
  assign shamt_sel = shamt_sel_q;
  assign hilo_rd   = hilo_rd_q;
  assign illegal   = illegal_q;
  assign md_start  = md_start_q;
  assign md_op     = md_op_q;
  assign md_done   = md_done_q;

endmodule
